// File: rtl/chip8_pkg.sv
// Shared types and the keypad matrix map for the CHIP-8 keypad front end.
package chip8_pkg;

  typedef logic [3:0] key_t;

  localparam int unsigned NUM_KEYS = 16;

  // KEYMAP[row][col] gives the CHIP-8 key value wired at that matrix position.
  localparam key_t KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hC},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hA, 4'h0, 4'hB, 4'hF}
  };

  typedef enum logic [1:0] {IDLE, ARMED, HELD} wait_state_t;

  typedef enum logic {DRIVE, SAMPLE} scan_state_t;

  function automatic key_t lowest_key(input logic [NUM_KEYS-1:0] keys);
    key_t k;
    k = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) k = key_t'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: stable bit flips after DEBOUNCE_SCANS consecutive disagreeing samples.
module key_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en,
  input  logic sample,
  output logic stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (en) begin
      if (sample == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
        cnt_d    = '0;
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/chip8_keypad.sv
// 4x4 hex keypad scanner with per-key debounce and the FX0A wait-for-key handshake.
module chip8_keypad
  import chip8_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [3:0]          row_in,
  output logic [3:0]          col_out,
  output logic [NUM_KEYS-1:0] key_state,
  input  logic                wait_req,
  output logic                key_valid,
  output logic [3:0]          key_idx
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  scan_state_t         scan_q, scan_d;
  logic [1:0]          col_q, col_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;

  always_comb begin
    scan_d   = scan_q;
    col_d    = col_q;
    settle_d = settle_q;
    unique case (scan_q)
      DRIVE: begin
        if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          scan_d   = SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      SAMPLE: begin
        col_d  = col_q + 2'd1;
        scan_d = DRIVE;
      end
      default: scan_d = DRIVE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      scan_q   <= DRIVE;
      col_q    <= 2'd0;
      settle_q <= '0;
    end else begin
      scan_q   <= scan_d;
      col_q    <= col_d;
      settle_q <= settle_d;
    end
  end

  assign col_out = ~(4'b0001 << col_q);

  // Debouncers are indexed by matrix position; remapped to key values below.
  logic [NUM_KEYS-1:0] stable_rc;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_key (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     ((scan_q == SAMPLE) && (col_q == 2'(c))),
        .sample (~row_in[r]),
        .stable (stable_rc[r*4+c])
      );
    end
  end

  always_comb begin
    key_state = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        key_state[KEYMAP[r][c]] = stable_rc[r*4+c];
      end
    end
  end

  wait_state_t         wait_q, wait_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic [NUM_KEYS-1:0] cand;
  key_t                cap_q, cap_d;
  key_t                idx_q, idx_d;
  logic                valid_q, valid_d;

  assign cand = key_state & ~snap_q;

  always_comb begin
    wait_d  = wait_q;
    snap_d  = snap_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    unique case (wait_q)
      IDLE: begin
        // No re-arm in the cycle the completion pulse is visible.
        if (wait_req && !valid_q) begin
          snap_d = key_state;
          wait_d = ARMED;
        end
      end
      ARMED: begin
        if (!wait_req) begin
          wait_d = IDLE;
        end else begin
          // Releasing a key held at arm time makes it eligible on re-press.
          snap_d = snap_q & key_state;
          if (cand != '0) begin
            cap_d  = lowest_key(cand);
            wait_d = HELD;
          end
        end
      end
      HELD: begin
        if (!wait_req) begin
          wait_d = IDLE;
        end else if (!key_state[cap_q]) begin
          valid_d = 1'b1;
          idx_d   = cap_q;
          wait_d  = IDLE;
        end
      end
      default: wait_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wait_q  <= IDLE;
      snap_q  <= '0;
      cap_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      snap_q  <= snap_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign key_valid = valid_q;
  assign key_idx   = idx_q;

endmodule

// File: doc/chip8_keypad.md
Name: chip8_keypad

Overview:
- Scans the 4x4 hex keypad matrix, debounces each key, and presents the 16-bit key state to the CHIP-8 core for EX9E/EXA1.
- Provides the FX0A "wait for key" handshake: a key index is returned after a full press-and-release.
- Sits directly upstream of the core, inside top_level, between the keypad PMOD pins and the core's key inputs.

Parameters:
- SETTLE_CYCLES, 1000: clk_in cycles a column is driven before rows are sampled (10 us at 100 MHz); must be >= 1.
- DEBOUNCE_SCANS, 4: consecutive disagreeing samples of a key required to flip its stable state; must be >= 1.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  synchronous, active-high reset.
- row_in  input  4  matrix rows; active low, externally pulled up; pre-synchronised by top_level.
- col_out  output  4  matrix columns; exactly one driven low (active), the others high.
- key_state  output  16  debounced state; bit k = CHIP-8 key k held.
- wait_req  input  1  level from core while executing FX0A.
- key_valid  output  1  one-cycle pulse: FX0A key completed.
- key_idx  output  4  key value; valid only when key_valid = 1.

Behaviour:
- Reset values: col_out = 4'b1110 (column 0 active), key_state = 0, key_valid = 0, key_idx = 0. Scan FSM in DRIVE for column 0, settle counter = 0, debounce counters = 0, wait FSM = IDLE.
- Scan FSM states:
  - DRIVE(c): count SETTLE_CYCLES cycles, then go to SAMPLE(c).
  - SAMPLE(c): one cycle; latch ~row_in for column c; set c = (c+1) mod 4; go to DRIVE.
  - col_out changes on the SAMPLE to DRIVE transition.
  - One full scan = 4*(SETTLE_CYCLES+1) cycles; column 3 wraps to column 0.
- Key mapping (row r, column c), from the package table:
  - r0: 1 2 3 C
  - r1: 4 5 6 D
  - r2: 7 8 9 E
  - r3: A 0 B F
- Debounce, per key, updated only in that key's SAMPLE cycle:
  - If sample == key_state[k], clear the counter.
  - Otherwise increment the counter. On reaching DEBOUNCE_SCANS, toggle key_state[k] and clear the counter.
  - key_state updates the cycle after SAMPLE.
  - Counter width = $clog2(DEBOUNCE_SCANS+1).
- Wait FSM states:
  - IDLE: on wait_req = 1, record snapshot = key_state and go to ARMED.
  - ARMED: candidates = key_state & ~snapshot. A key released during ARMED clears its snapshot bit, so a key held at arm time qualifies only after release and re-press. If candidates != 0, capture the lowest-indexed candidate and go to HELD.
  - HELD: when key_state[captured] = 0, assert key_valid for one cycle with key_idx = captured, then go to IDLE. The core drops wait_req after key_valid.
  - DONE gap: the FSM does not re-arm in the cycle key_valid is high. It re-arms from IDLE only if wait_req is still 1 on the next cycle.
- Abort: wait_req = 0 in ARMED or HELD returns to IDLE next cycle with no pulse.
- Simultaneous presses in the same scan: lowest key value wins. Other keys pressed during HELD are ignored.
- Reset mid-operation (scan or wait) returns everything to reset values next cycle. An in-flight capture is discarded and no key_valid is issued.
- key_state stays live and unaffected by the wait FSM at all times.

Decomposition:
- Package chip8_pkg:
  - typedef key_t (logic [3:0]).
  - localparam KEYMAP[4][4] of key_t.
  - localparam NUM_KEYS = 16.
  - enum wait_state_t {IDLE, ARMED, HELD}.
- One sub-module, key_debounce: single-key counter plus stable bit, enable = that key's sample strobe, parameter DEBOUNCE_SCANS. Instantiated 16 times in a generate loop.
- Scan FSM and wait FSM live in chip8_keypad.

Test Plan:
All scenarios use SETTLE_CYCLES = 2, DEBOUNCE_SCANS = 2 (scan = 12 cycles) and a matrix model that drives row_in from the active column and a pressed-key set.
- Reset: after rst_in, col_out = 1110 and key_state = 0. col_out then steps 1101, 1011, 0111, 1110 at intervals of 3 cycles.
- Debounce: hold (r1,c2) → key_state = 16'h0040 (key 6) within 2 scans. A 1-scan glitch on (r0,c0) never sets bit 1.
- Release: hold r3,c3 (key F) and release → bit 15 sets after 2 scans and clears 2 scans after release.
- FX0A basic: wait_req = 1, then press and release key A → exactly one key_valid pulse with key_idx = 4'hA, only after bit 10 clears.
- Priority and held-before-arm:
  - Key 5 held before wait_req rises; then press key 3 and key 9 together → capture 3, pulse with key_idx = 3.
  - Key 5 alone never fires until released and re-pressed.
- Abort and reset: drop wait_req during HELD → no key_valid. Assert rst_in during ARMED → no key_valid and key_state = 0 next cycle.
